// File: rtl/chiplib_clkgate_ctrl.sv
// Clock-enable controller for a post-ICG: gates the local clock after a
// programmable idle period and restores it with a settle delay on demand.
module chiplib_clkgate_ctrl #(
   parameter int IDLE_CNT_W = 8,
   parameter int WAKE_DLY   = 2,
   parameter int GCNT_W     = 16
) (
   input  logic                  clkin,
   input  logic                  rst_n,
   input  logic                  en_gating,
   input  logic                  force_on,
   input  logic                  busy,
   input  logic [IDLE_CNT_W-1:0] idle_thresh,
   input  logic                  wake_req,
   input  logic                  cnt_clr,
   output logic                  clken,
   output logic                  clk_active,
   output logic                  wake_ack,
   output logic [1:0]            state,
   output logic [GCNT_W-1:0]     gate_cnt
);

   typedef enum logic [1:0] {
      S_RUN   = 2'b00,
      S_IDLE  = 2'b01,
      S_GATED = 2'b10,
      S_WAKE  = 2'b11
   } state_e;

   localparam logic [3:0] WakeLast = 4'(WAKE_DLY - 1);

   state_e                state_q, state_d;
   logic [IDLE_CNT_W-1:0] idle_q, idle_d;
   logic [3:0]            wake_q, wake_d;
   logic [GCNT_W-1:0]     gcnt_q, gcnt_d;
   logic                  clken_q, clken_d;
   logic                  act_q, act_d;
   logic                  ack_q, ack_d;
   logic                  hold;
   logic                  gate_ev;

   always_comb begin
      hold    = busy | force_on | wake_req | ~en_gating;
      state_d = state_q;
      idle_d  = idle_q;
      wake_d  = wake_q;
      gate_ev = 1'b0;
      unique case (state_q)
         S_RUN: begin
            idle_d = '0;
            if (!hold) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (hold) begin
               state_d = S_RUN;
               idle_d  = '0;
            end else if (idle_q >= idle_thresh) begin
               state_d = S_GATED;
               idle_d  = '0;
               gate_ev = 1'b1;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
         S_GATED: begin
            if (hold) begin
               state_d = S_WAKE;
               wake_d  = '0;
            end
         end
         S_WAKE: begin
            // inputs are deliberately ignored until the clock has settled
            wake_d = wake_q + 4'd1;
            if (wake_q == WakeLast) begin
               state_d = S_RUN;
               wake_d  = '0;
            end
         end
      endcase

      clken_d = (state_d != S_GATED);
      act_d   = (state_d == S_RUN) || (state_d == S_IDLE);
      ack_d   = (state_d == S_RUN) && wake_req;

      gcnt_d = gcnt_q;
      if (cnt_clr) begin
         gcnt_d = '0;
      end else if (gate_ev && (gcnt_q != '1)) begin
         gcnt_d = gcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RUN;
         idle_q  <= '0;
         wake_q  <= '0;
         gcnt_q  <= '0;
         clken_q <= 1'b1;
         act_q   <= 1'b1;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idle_q  <= idle_d;
         wake_q  <= wake_d;
         gcnt_q  <= gcnt_d;
         clken_q <= clken_d;
         act_q   <= act_d;
         ack_q   <= ack_d;
      end
   end

   assign clken      = clken_q;
   assign clk_active = act_q;
   assign wake_ack   = ack_q;
   assign state      = state_q;
   assign gate_cnt   = gcnt_q;

endmodule

// File: tb/tb_chiplib_clkgate_ctrl.sv
// Bench for chiplib_clkgate_ctrl: directed vector table, corner sequences
// and randomized traffic against a cycle-level behavioural model.
module tb_chiplib_clkgate_ctrl;

   localparam int WD = 2;

   logic        clkin = 1'b0;
   logic        rst_n;
   logic        en_gating, force_on, busy, wake_req, cnt_clr;
   logic [7:0]  idle_thresh;
   logic        clken, clk_active, wake_ack;
   logic [1:0]  state;
   logic [15:0] gate_cnt;
   logic        s_ce, s_ca, s_ak;
   logic [1:0]  s_st;
   logic [3:0]  s_gc;

   always #5 clkin = ~clkin;

   chiplib_clkgate_ctrl #(.IDLE_CNT_W(8), .WAKE_DLY(WD), .GCNT_W(16)) u_dut (
      .clkin(clkin), .rst_n(rst_n), .en_gating(en_gating),
      .force_on(force_on), .busy(busy), .idle_thresh(idle_thresh),
      .wake_req(wake_req), .cnt_clr(cnt_clr), .clken(clken),
      .clk_active(clk_active), .wake_ack(wake_ack), .state(state),
      .gate_cnt(gate_cnt)
   );

   chiplib_clkgate_ctrl #(.IDLE_CNT_W(8), .WAKE_DLY(WD), .GCNT_W(4)) u_sat (
      .clkin(clkin), .rst_n(rst_n), .en_gating(en_gating),
      .force_on(force_on), .busy(busy), .idle_thresh(idle_thresh),
      .wake_req(wake_req), .cnt_clr(cnt_clr), .clken(s_ce),
      .clk_active(s_ca), .wake_ack(s_ak), .state(s_st),
      .gate_cnt(s_gc)
   );

   int total = 0;
   int bad   = 0;

   // model: quiet = consecutive non-hold samples with the clock on
   int quiet, wake_left, gc16, gc4;
   bit gated, m_ack;

   typedef struct {
      bit       en, frc, bsy, wrq;
      bit [1:0] st;
      bit       ce, ca, ak;
      int       gc;
   } vec_t;

   vec_t vec[$];

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      quiet = 0; wake_left = 0; gc16 = 0; gc4 = 0;
      gated = 0; m_ack = 0;
   endfunction

   function automatic int m_state();
      if (gated) return 2;
      if (wake_left > 0) return 3;
      if (quiet > 0) return 1;
      return 0;
   endfunction

   function automatic void model_step();
      bit hold;
      bit ev;
      hold = busy | force_on | wake_req | ~en_gating;
      ev = 0;
      if (wake_left > 0) wake_left--;
      else if (gated) begin
         if (hold) begin gated = 0; wake_left = WD; end
      end else if (hold) quiet = 0;
      else if (quiet >= 1 && quiet - 1 >= int'(idle_thresh)) begin
         gated = 1; quiet = 0; ev = 1;
      end else quiet++;
      if (cnt_clr) begin gc16 = 0; gc4 = 0; end
      else if (ev) begin
         if (gc16 < 65535) gc16++;
         if (gc4 < 15) gc4++;
      end
      m_ack = (m_state() == 0) && wake_req;
   endfunction

   task automatic tick();
      @(posedge clkin);
      model_step();
      #1;
      check("m_state", {30'd0, state}, m_state());
      check("m_outs", {29'd0, clken, clk_active, wake_ack},
            {29'd0, !gated, !gated && wake_left == 0, m_ack});
      check("m_gcnt", {16'd0, gate_cnt}, gc16);
      check("m_gcnt4", {28'd0, s_gc}, gc4);
   endtask

   function automatic vec_t row(bit en, bit frc, bit bsy, bit wrq,
                                bit [1:0] st, bit ce, bit ca, bit ak, int gc);
      vec_t r;
      r.en = en; r.frc = frc; r.bsy = bsy; r.wrq = wrq;
      r.st = st; r.ce = ce; r.ca = ca; r.ak = ak; r.gc = gc;
      return r;
   endfunction

   initial begin
      int n;
      // idle gating, wake handshake, abort, force_on, en_gating
      for (int i = 0; i < 4; i++) vec.push_back(row(1,0,0,0, 1,1,1,0, 0));
      for (int i = 0; i < 2; i++) vec.push_back(row(1,0,0,0, 2,0,0,0, 1));
      for (int i = 0; i < 2; i++) vec.push_back(row(1,0,0,1, 3,1,0,0, 1));
      for (int i = 0; i < 2; i++) vec.push_back(row(1,0,0,1, 0,1,1,1, 1));
      for (int i = 0; i < 3; i++) vec.push_back(row(1,0,0,0, 1,1,1,0, 1));
      vec.push_back(row(1,0,1,0, 0,1,1,0, 1));
      for (int i = 0; i < 4; i++) vec.push_back(row(1,0,0,0, 1,1,1,0, 1));
      vec.push_back(row(1,0,0,0, 2,0,0,0, 2));
      for (int i = 0; i < 2; i++) vec.push_back(row(1,1,0,0, 3,1,0,0, 2));
      for (int i = 0; i < 4; i++) vec.push_back(row(1,1,0,0, 0,1,1,0, 2));
      for (int i = 0; i < 2; i++) vec.push_back(row(0,0,0,0, 0,1,1,0, 2));
      for (int i = 0; i < 4; i++) vec.push_back(row(1,0,0,0, 1,1,1,0, 2));
      vec.push_back(row(1,0,0,0, 2,0,0,0, 3));
      for (int i = 0; i < 2; i++) vec.push_back(row(0,0,0,0, 3,1,0,0, 3));
      for (int i = 0; i < 3; i++) vec.push_back(row(0,0,0,0, 0,1,1,0, 3));

      rst_n = 0; en_gating = 1; force_on = 0; busy = 0;
      wake_req = 0; cnt_clr = 0; idle_thresh = 8'd3;
      model_reset();
      #12;
      check("rst_state", {30'd0, state}, 0);
      check("rst_outs", {29'd0, clken, clk_active, wake_ack}, 3'b110);
      check("rst_gcnt", {16'd0, gate_cnt}, 0);
      rst_n = 1;

      foreach (vec[i]) begin
         en_gating = vec[i].en; force_on = vec[i].frc;
         busy = vec[i].bsy; wake_req = vec[i].wrq;
         tick();
         check($sformatf("vec%0d", i),
               {27'd0, state, clken, clk_active, wake_ack},
               {27'd0, vec[i].st, vec[i].ce, vec[i].ca, vec[i].ak});
         check($sformatf("vec%0d_gc", i), {16'd0, gate_cnt}, vec[i].gc);
      end

      // async reset while gated, between edges
      en_gating = 1; force_on = 0; busy = 0; wake_req = 0;
      n = 0;
      while (state != 2'b10 && n < 20) begin tick(); n++; end
      check("reach_gated", {30'd0, state}, 2);
      #2;
      rst_n = 0;
      model_reset();
      #1;
      check("arst_state", {30'd0, state}, 0);
      check("arst_clken", {31'd0, clken}, 1);
      check("arst_act", {31'd0, clk_active}, 1);
      check("arst_gcnt", {16'd0, gate_cnt}, 0);
      #3;
      rst_n = 1;

      // 17 gate cycles: 4-bit counter saturates, 16-bit keeps counting
      idle_thresh = 8'd0;
      for (int i = 0; i < 17; i++) begin
         busy = 0; tick(); tick();
         busy = 1; tick();
         busy = 0; tick(); tick();
      end
      check("sat_gc4", {28'd0, s_gc}, 15);
      check("sat_gc16", {16'd0, gate_cnt}, 17);
      tick();
      cnt_clr = 1; tick(); cnt_clr = 0;
      check("clr_win_state", {30'd0, state}, 2);
      check("clr_win_gc4", {28'd0, s_gc}, 0);
      check("clr_win_gc16", {16'd0, gate_cnt}, 0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         busy = ($urandom_range(0, 5) == 0);
         force_on = ($urandom_range(0, 31) == 0);
         en_gating = ($urandom_range(0, 19) != 0);
         if (wake_req) wake_req = ($urandom_range(0, 3) != 0);
         else wake_req = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 7) == 0) idle_thresh = 8'($urandom_range(0, 6));
         cnt_clr = ($urandom_range(0, 39) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
